// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and constants for the register-file write arbiter
package regfile_arb_pkg;

    // Which requester won the most recent grant; the other one wins the next conflict
    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } arb_state_t;

    // XZR: writes to this index are consumed but never reach the register file
    localparam int XZR = 31;

    // Default datapath sizes for the LEGv8 register file
    localparam int REGFILE_N  = 64;
    localparam int REGFILE_AW = 5;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick
import regfile_arb_pkg::*;

module rr_pick2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  arb_state_t i_last,
    input  logic       i_stall,
    output logic       o_grant0,
    output logic       o_grant1
);

    logic w_conflict;

    assign w_conflict = i_valid0 && i_valid1;

    // A lone valid wins outright; on a conflict the requester not granted last time wins
    always_comb begin
        o_grant0 = 1'b0;
        o_grant1 = 1'b0;
        if (!i_stall) begin
            if (w_conflict) begin
                o_grant0 = (i_last == LAST1);
                o_grant1 = (i_last == LAST0);
            end else begin
                o_grant0 = i_valid0;
                o_grant1 = i_valid1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin share of the register-file write port (optional ARB_STATS_EN conflict counter)
import regfile_arb_pkg::*;

module regfile_write_arbiter #(
    parameter int N        = REGFILE_N,
    parameter int AW       = REGFILE_AW,
    parameter int ZERO_REG = XZR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
`ifdef ARB_STATS_EN
    output logic [15:0]   conflict_cnt,
`endif
    input  logic          wr_stall,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data
);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic          w_grant0;
    logic          w_grant1;
    logic [AW-1:0] w_sel_addr;
    logic [N-1:0]  w_sel_data;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [N-1:0]  r_wr_data;

    rr_pick2 u_pick (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_state),
        .i_stall  (wr_stall),
        .o_grant0 (w_grant0),
        .o_grant1 (w_grant1)
    );

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Round-robin state register; reset makes req0 the winner of the first conflict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LAST1;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state follows the grant; no grant holds the state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LAST0: if (w_grant0) w_state_next = LAST0;
                   else if (w_grant1) w_state_next = LAST1;
            LAST1: if (w_grant1) w_state_next = LAST1;
                   else if (w_grant0) w_state_next = LAST0;
            default: w_state_next = LAST1;
        endcase
    end

    // Mux the granted requester onto the write path
    always_comb begin
        w_sel_addr = req0_addr;
        w_sel_data = req0_data;
        if (w_grant1) begin
            w_sel_addr = req1_addr;
            w_sel_data = req1_data;
        end
    end

    // Output stage: one-cycle write pulse; addr/data hold when nothing is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_wr_en   <= (w_sel_addr != AW'(ZERO_REG));
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

`ifdef ARB_STATS_EN
    logic [15:0] r_conflict_cnt;

    // Count unstalled edges where both requesters compete, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_conflict_cnt <= 16'h0000;
        end else if (req0_valid && req1_valid && !wr_stall && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'h0001;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid, wr_stall;
    logic [4:0]  req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
`ifdef ARB_STATS_EN
        .conflict_cnt (conflict_cnt),
`endif
        .wr_stall   (wr_stall),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic        stall;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic st);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        wr_stall   = st;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Higher-level model state
    int          m_last;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [63:0] m_data;

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);

        // {v0,a0,d0, v1,a1,d1, stall, exp r0,r1, exp en,addr,data after edge}
        vecs[0]  = '{1, 5'd3,  64'hDEAD_BEEF, 0, 5'd0,  64'd0,  0, 1, 0, 1, 5'd3,  64'hDEAD_BEEF};
        vecs[1]  = '{0, 5'd0,  64'd0,         0, 5'd0,  64'd0,  0, 0, 0, 0, 5'd3,  64'hDEAD_BEEF};
        vecs[2]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  0, 0, 1, 1, 5'd6,  64'h6};
        vecs[3]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  0, 1, 0, 1, 5'd5,  64'h5};
        vecs[4]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  0, 0, 1, 1, 5'd6,  64'h6};
        vecs[5]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  0, 1, 0, 1, 5'd5,  64'h5};
        vecs[6]  = '{0, 5'd0,  64'd0,         1, 5'd31, 64'h77, 0, 0, 1, 0, 5'd31, 64'h77};
        vecs[7]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  1, 0, 0, 0, 5'd31, 64'h77};
        vecs[8]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  1, 0, 0, 0, 5'd31, 64'h77};
        vecs[9]  = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  1, 0, 0, 0, 5'd31, 64'h77};
        vecs[10] = '{1, 5'd5,  64'h5,         1, 5'd6,  64'h6,  0, 1, 0, 1, 5'd5,  64'h5};
        vecs[11] = '{1, 5'd31, 64'h9,         0, 5'd0,  64'd0,  0, 1, 0, 0, 5'd31, 64'h9};

        do_reset();
        chk("reset_wr_en", {63'd0, wr_en}, 64'd0);
        chk("reset_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("reset_wr_data", wr_data, 64'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].stall);
            @(negedge clk);
            chk($sformatf("vec%0d_req0_ready", i), {63'd0, req0_ready}, {63'd0, vecs[i].r0});
            chk($sformatf("vec%0d_req1_ready", i), {63'd0, req1_ready}, {63'd0, vecs[i].r1});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wr_en", i), {63'd0, wr_en}, {63'd0, vecs[i].en});
            chk($sformatf("vec%0d_wr_addr", i), {59'd0, wr_addr}, {59'd0, vecs[i].addr});
            chk($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].data);
        end

        // Reset asserted while a write is on the output: outputs clear before the next edge
        drive(1'b1, 5'd7, 64'h1234_5678, 1'b0, 5'd0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst_pre_wr_en", {63'd0, wr_en}, 64'd1);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("midrst_wr_addr", {59'd0, wr_addr}, 64'd0);
        chk("midrst_wr_data", wr_data, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Both valid from reset: grants 0,1,0,1
        drive(1'b1, 5'd10, 64'hA0, 1'b1, 5'd11, 64'hB1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_req0_ready", k), {63'd0, req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr%0d_req1_ready", k), {63'd0, req1_ready}, (k % 2 == 1) ? 64'd1 : 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_wr_addr", k), {59'd0, wr_addr}, (k % 2 == 0) ? 64'd10 : 64'd11);
            chk($sformatf("rr%0d_wr_en", k), {63'd0, wr_en}, 64'd1);
        end

        // Randomised run against a rule-level model
        do_reset();
        m_last = 1; m_en = 1'b0; m_addr = 5'd0; m_data = 64'd0;
        begin
            logic        v0, v1, st, g0, g1;
            logic [4:0]  a0, a1;
            logic [63:0] d0, d1;
            v0 = 1'b0; v1 = 1'b0; a0 = 5'd0; a1 = 5'd0; d0 = 64'd0; d1 = 64'd0;
            for (int i = 0; i < 400; i++) begin
                // A requester that was not accepted keeps its request stable
                if (!v0) begin
                    v0 = 1'($urandom_range(0, 1));
                    a0 = 5'($urandom_range(0, 31));
                    d0 = {$urandom, $urandom};
                end
                if (!v1) begin
                    v1 = 1'($urandom_range(0, 1));
                    a1 = 5'($urandom_range(0, 31));
                    d1 = {$urandom, $urandom};
                end
                st = ($urandom_range(0, 3) == 0);
                drive(v0, a0, d0, v1, a1, d1, st);

                g0 = 1'b0; g1 = 1'b0;
                if (!st) begin
                    if (v0 && v1) begin
                        if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
                    end else begin
                        g0 = v0;
                        g1 = v1;
                    end
                end

                @(negedge clk);
                chk($sformatf("rnd%0d_req0_ready", i), {63'd0, req0_ready}, {63'd0, g0});
                chk($sformatf("rnd%0d_req1_ready", i), {63'd0, req1_ready}, {63'd0, g1});

                m_en = 1'b0;
                if (g0) begin
                    m_en = (a0 != 5'd31); m_addr = a0; m_data = d0; m_last = 0;
                end else if (g1) begin
                    m_en = (a1 != 5'd31); m_addr = a1; m_data = d1; m_last = 1;
                end

                @(posedge clk);
                #1;
                chk($sformatf("rnd%0d_wr_en", i), {63'd0, wr_en}, {63'd0, m_en});
                chk($sformatf("rnd%0d_wr_addr", i), {59'd0, wr_addr}, {59'd0, m_addr});
                chk($sformatf("rnd%0d_wr_data", i), wr_data, m_data);

                if (g0) v0 = 1'b0;
                if (g1) v1 = 1'b0;
            end
        end

`ifdef ARB_STATS_EN
        // Conflict counter: five conflict cycles, one stalled, then saturation
        do_reset();
        chk("cnt_reset", {48'd0, conflict_cnt}, 64'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, (k == 2) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
        end
        chk("cnt_four", {48'd0, conflict_cnt}, 64'd4);
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0);
        for (int k = 0; k < 65531; k++) begin
            @(posedge clk);
        end
        #1;
        chk("cnt_full", {48'd0, conflict_cnt}, 64'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_saturate", {48'd0, conflict_cnt}, 64'hFFFF);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
